// File: rtl/uart_byte_rx_if.sv
// Serial line plus received-byte outputs of uart_byte_rx.
// The master side is the receiver; the slave side drives rx and consumes the pulses.
interface uart_byte_rx_if;
    logic       rx;
    logic       valid;
    logic [7:0] data;
    logic       frame_err;
    logic       busy;

    modport master (
        input  rx,
        output valid,
        output data,
        output frame_err,
        output busy
    );

    modport slave (
        output rx,
        input  valid,
        input  data,
        input  frame_err,
        input  busy
    );
endinterface

// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8N1 serial byte receiver (8E1 when UART_BYTE_RX_PARITY_EN is defined) with mid-bit sampling.
// Latency: rx fall to valid = 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 clocks (+CLKS_PER_BIT with parity).
// Backpressure: none; valid and frame_err are one-cycle pulses the consumer always takes.
module uart_byte_rx #(
    parameter int CLK_HZ       = 100_000_000,
    parameter int BAUD         = 115_200,
    parameter int CLKS_PER_BIT = CLK_HZ / BAUD,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic           clk,
    input  logic           rst_n,
    uart_byte_rx_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_BYTE_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        BRK
    } state_t;

    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    logic             sync1_q, sync1_d;
    logic             rx_s_q, rx_s_d;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             valid_q, valid_d;
    logic [7:0]       data_q, data_d;
    logic             frame_err_q, frame_err_d;
    logic             busy_q, busy_d;
`ifdef UART_BYTE_RX_PARITY_EN
    logic             par_err_q, par_err_d;
`endif

    always_comb begin
        sync1_d     = bus.rx;
        rx_s_d      = sync1_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        valid_d     = 1'b0;
        data_d      = data_q;
        frame_err_d = 1'b0;
`ifdef UART_BYTE_RX_PARITY_EN
        par_err_d   = par_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    state_d   = START;
                    cnt_d     = '0;
                    bit_idx_d = '0;
                end
            end
            START: begin
                // Start bit must still be low at its midpoint, otherwise it was a glitch.
                if (cnt_q == HALF_M1) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = rx_s_q ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_q == FULL_M1) begin
                    shift_d   = {rx_s_q, shift_q[7:1]};
                    cnt_d     = '0;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_BYTE_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef UART_BYTE_RX_PARITY_EN
            PARITY: begin
                if (cnt_q == FULL_M1) begin
                    par_err_d = (^shift_q) ^ rx_s_q;
                    cnt_d     = '0;
                    state_d   = STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif
            STOP: begin
                // Leaving at mid-stop-bit lets a back-to-back start edge be caught.
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        state_d = IDLE;
`ifdef UART_BYTE_RX_PARITY_EN
                        if (par_err_q) begin
                            frame_err_d = 1'b1;
                        end else begin
                            valid_d = 1'b1;
                            data_d  = shift_q;
                        end
`else
                        valid_d = 1'b1;
                        data_d  = shift_q;
`endif
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = BRK;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            BRK: begin
                if (rx_s_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 1'b1;
            rx_s_q      <= 1'b1;
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            valid_q     <= 1'b0;
            data_q      <= 8'h00;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef UART_BYTE_RX_PARITY_EN
            par_err_q   <= 1'b0;
`endif
        end else begin
            sync1_q     <= sync1_d;
            rx_s_q      <= rx_s_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
`ifdef UART_BYTE_RX_PARITY_EN
            par_err_q   <= par_err_d;
`endif
        end
    end

    assign bus.valid     = valid_q;
    assign bus.data      = data_q;
    assign bus.frame_err = frame_err_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_uart_byte_rx.sv
// Bench for uart_byte_rx: directed and random serial frames, scoreboard of expected pulses.
// Stimulus pushes the expected outcome of each frame; a negedge monitor pops and compares.
module tb_uart_byte_rx;

    localparam int CLK_HZ = 1_000_000;
    localparam int BAUD   = 100_000;
    localparam int CPB    = CLK_HZ / BAUD;
`ifdef UART_BYTE_RX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    // Sync delay, half start bit, 8 data bits + stop (+parity), then registered output.
    localparam int LAT = 2 + CPB / 2 + (9 + PAR_BITS) * CPB + 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    uart_byte_rx_if u_if ();

    uart_byte_rx #(
        .CLK_HZ(CLK_HZ),
        .BAUD  (BAUD)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (u_if.master)
    );

    typedef struct {
        bit         is_err;
        logic [7:0] dat;
        int         due;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         errors = 0;
    int         checks = 0;
    logic [7:0] last_good = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: a frame yields a byte only if stop is high and (when enabled) parity is even.
    task automatic model_frame(input logic [7:0] b, input bit par_ok, input bit stop_ok, input int c0);
        exp_t e;
        e.due = c0 + LAT;
        if (stop_ok && par_ok) begin
            e.is_err  = 1'b0;
            e.dat     = b;
            last_good = b;
        end else begin
            e.is_err = 1'b1;
            e.dat    = last_good;
        end
        exp_q.push_back(e);
    endtask

    task automatic drive_bit(input logic v);
        u_if.rx = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic idle_clks(input int n);
        u_if.rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit par_ok, input bit stop_ok);
        model_frame(b, par_ok, stop_ok, cyc);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_BYTE_RX_PARITY_EN
        drive_bit(par_ok ? ^b : ~^b);
`endif
        drive_bit(stop_ok);
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        check({tag, "_valid"}, u_if.valid, 0);
        check({tag, "_data"}, u_if.data, 8'h00);
        check({tag, "_frame_err"}, u_if.frame_err, 0);
        check({tag, "_busy"}, u_if.busy, 0);
    endtask

    always @(negedge clk) begin
        if (rst_n && (u_if.valid === 1'b1 || u_if.frame_err === 1'b1)) begin
            check("no_dual_pulse", u_if.valid & u_if.frame_err, 0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: valid=%0b frame_err=%0b data=0x%0h, expected no pulse (cycle %0d)",
                         u_if.valid, u_if.frame_err, u_if.data, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("pulse_kind_frame_err", u_if.frame_err, mon_e.is_err);
                check("pulse_data", u_if.data, mon_e.dat);
                check("pulse_cycle", cyc, mon_e.due);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int saw_busy;
        logic [7:0] b;
        bit stop_ok;
        bit par_ok;

        u_if.rx = 1'b1;
        repeat (3) @(posedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle_clks(10);
        check("idle_busy", u_if.busy, 0);

        // Single good byte.
        send_frame(8'hA5, 1'b1, 1'b1);
        idle_clks(10);

        // Back-to-back command/record bytes with zero idle.
        send_frame(8'h01, 1'b1, 1'b1);
        send_frame(8'h1B, 1'b1, 1'b1);
        send_frame(8'h02, 1'b1, 1'b1);
        idle_clks(10);

        // Short glitch must not start a frame.
        saw_busy = 0;
        u_if.rx = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        u_if.rx = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (u_if.busy === 1'b1) saw_busy = 1;
        end
        check("glitch_busy_seen", saw_busy, 1);
        check("glitch_back_idle", u_if.busy, 0);

        // Bad stop followed by a held-low line.
        send_frame(8'h3C, 1'b1, 1'b0);
        u_if.rx = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("break_busy", u_if.busy, 1);
        idle_clks(20);
        check("break_released_idle", u_if.busy, 0);
        send_frame(8'h55, 1'b1, 1'b1);
        idle_clks(10);

        // Reset in the middle of the 4th data bit of 0xFF.
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(1'b1);
        u_if.rx = 1'b1;
        repeat (CPB / 2) @(posedge clk);
        #1;
        rst_n     = 1'b0;
        last_good = 8'h00;
        check_reset_outputs("midframe_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle_clks(30);
        check("post_reset_idle", u_if.busy, 0);
        send_frame(8'h12, 1'b1, 1'b1);
        idle_clks(10);

`ifdef UART_BYTE_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1);
        idle_clks(5);
        send_frame(8'h07, 1'b0, 1'b1);
        idle_clks(5);
`endif

        // Randomised traffic: mixed payload, commands, bad stops and gaps.
        for (int n = 0; n < 24; n++) begin
            b = 8'($urandom);
            if ($urandom_range(0, 4) == 0) b = ($urandom_range(0, 1) == 0) ? 8'h01 : 8'h02;
            stop_ok = ($urandom_range(0, 7) != 0);
`ifdef UART_BYTE_RX_PARITY_EN
            par_ok = ($urandom_range(0, 5) != 0);
`else
            par_ok = 1'b1;
`endif
            send_frame(b, par_ok, stop_ok);
            if (!stop_ok) begin
                u_if.rx = 1'b0;
                repeat ($urandom_range(0, 20)) @(posedge clk);
                #1;
                idle_clks($urandom_range(2, 6));
            end else if ($urandom_range(0, 3) != 0) begin
                idle_clks($urandom_range(1, 15));
            end
        end

        idle_clks(LAT + 20);
        check("scoreboard_drained", exp_q.size(), 0);
        check("final_idle", u_if.busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
